// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: state encoding and counter sizing.
package serial_pkg;

    // Two-bit state codes; the fourth code is unused and recovers to IDLE.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_SHIFT = SHIFT,
        ST_DONE  = DONE
    } state_t;

    // Bits needed to hold a count of 0..width ones without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register. Zeros are shifted in behind the
// data, so once a word has fully left, serial_out rests at 0.
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data_in,
    output logic             serial_out
);

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shifted;

    // Direction of travel is fixed at elaboration time.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_shifted  = {1'b0, r_shift[WIDTH-1:1]};
            assign serial_out = r_shift[0];
        end else begin : g_msb_first
            assign w_shifted  = {r_shift[WIDTH-2:0], 1'b0};
            assign serial_out = r_shift[WIDTH-1];
        end
    endgenerate

    // Load takes priority over shift; reset clears the whole register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift <= '0;
        end else if (load) begin
            r_shift <= data_in;
        end else if (shift) begin
            r_shift <= w_shifted;
        end
    end

endmodule

// File: rtl/serial_word_tx.sv
// Serial word transmitter: accepts a word on start/ready, shifts it out one
// bit per clock with a valid qualifier, pulses done and reports the 1s count.
module serial_word_tx
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [WIDTH-1:0]              data_in,
    output logic                          ready,
    output logic                          bits,
    output logic                          bit_valid,
    output logic                          done,
    output logic [cnt_width(WIDTH)-1:0]   ones_sent
);

    localparam int CW = cnt_width(WIDTH);

    state_t        r_state;
    logic          r_ready;
    logic          r_bit_valid;
    logic          r_done;
    logic [CW-1:0] r_bit_cnt;
    logic [CW-1:0] r_ones_sent;

    logic          w_load;
    logic          w_shift;
    logic          w_serial_out;

    // A word is accepted only from IDLE; start elsewhere is dropped.
    assign w_load  = (r_state == ST_IDLE) && start;
    assign w_shift = (r_state == ST_SHIFT);

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_piso (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .shift      (w_shift),
        .data_in    (data_in),
        .serial_out (w_serial_out)
    );

    // Control FSM with bit counter and ones counter; all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_bit_valid <= 1'b0;
            r_done      <= 1'b0;
            r_bit_cnt   <= '0;
            r_ones_sent <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state     <= ST_SHIFT;
                        r_ready     <= 1'b0;
                        r_bit_valid <= 1'b1;
                        r_bit_cnt   <= CW'(WIDTH);
                        r_ones_sent <= '0;
                    end
                end
                ST_SHIFT: begin
                    // The shift register output is the bit on the line this cycle.
                    r_ones_sent <= r_ones_sent + CW'(w_serial_out);
                    r_bit_cnt   <= r_bit_cnt - CW'(1);
                    if (r_bit_cnt == CW'(1)) begin
                        r_state     <= ST_DONE;
                        r_bit_valid <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_ready     <= 1'b1;
                    r_bit_valid <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    // The shift register is zero outside SHIFT, so it can drive bits directly.
    assign bits      = w_serial_out;
    assign ready     = r_ready;
    assign bit_valid = r_bit_valid;
    assign done      = r_done;
    assign ones_sent = r_ones_sent;

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: an LSB-first and an MSB-first instance share the
// same stimulus and are checked every cycle against a queue of expected outputs.
module tb_serial_word_tx;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  data_in = '0;

    logic          ready_l, bits_l, valid_l, done_l;
    logic [CW-1:0] ones_l;
    logic          ready_m, bits_m, valid_m, done_m;
    logic [CW-1:0] ones_m;

    int checks = 0;
    int failures = 0;
    int words_accepted = 0;

    serial_word_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .ready(ready_l), .bits(bits_l), .bit_valid(valid_l), .done(done_l), .ones_sent(ones_l)
    );

    serial_word_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .ready(ready_m), .bits(bits_m), .bit_valid(valid_m), .done(done_m), .ones_sent(ones_m)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected outputs for the current and future cycles; empty means idle.
    typedef struct {
        logic          ready;
        logic          bl;
        logic          bm;
        logic          valid;
        logic          done;
        logic [CW-1:0] ol;
        logic [CW-1:0] om;
    } exp_t;

    exp_t          exp_q[$];
    logic [CW-1:0] last_ones = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // One accepted word: W payload cycles then one done cycle.
    task automatic push_word(input logic [W-1:0] w);
        exp_t e;
        int   cl = 0;
        int   cm = 0;
        for (int i = 0; i < W; i++) begin
            e.ready = 1'b0; e.bl = w[i]; e.bm = w[W-1-i];
            e.valid = 1'b1; e.done = 1'b0;
            e.ol = CW'(cl); e.om = CW'(cm);
            exp_q.push_back(e);
            cl += int'(w[i]);
            cm += int'(w[W-1-i]);
        end
        e.ready = 1'b0; e.bl = 1'b0; e.bm = 1'b0; e.valid = 1'b0; e.done = 1'b1;
        e.ol = CW'($countones(w)); e.om = CW'($countones(w));
        exp_q.push_back(e);
        words_accepted++;
    endtask

    // Advance the model across one rising edge using the inputs seen there.
    task automatic model_edge();
        exp_t e;
        if (!reset) begin
            exp_q.delete();
            last_ones = '0;
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.done) last_ones = e.ol;
        end else if (start) begin
            push_word(data_in);
        end
    endtask

    function automatic exp_t current_exp();
        exp_t e;
        if (exp_q.size() != 0) return exp_q[0];
        e.ready = 1'b1; e.bl = 1'b0; e.bm = 1'b0; e.valid = 1'b0; e.done = 1'b0;
        e.ol = last_ones; e.om = last_ones;
        return e;
    endfunction

    task automatic compare_all();
        exp_t e;
        e = current_exp();
        chk("ready_l", ready_l, e.ready);
        chk("ready_m", ready_m, e.ready);
        chk("bits_l", bits_l, e.bl);
        chk("bits_m", bits_m, e.bm);
        chk("valid_l", valid_l, e.valid);
        chk("valid_m", valid_m, e.valid);
        chk("done_l", done_l, e.done);
        chk("done_m", done_m, e.done);
        chk("ones_l", ones_l, e.ol);
        chk("ones_m", ones_m, e.om);
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Table vectors: bit sequences written first-sent-bit leftmost.
    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] seq_l;
        logic [W-1:0] seq_m;
        int           ones;
        bit           poke;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input int idx, input vec_t v);
        logic [W-1:0] sl;
        logic [W-1:0] sm;
        sl = '0;
        sm = '0;
        data_in = v.data;
        start   = 1'b1;
        step();
        start   = 1'b0;
        data_in = W'($urandom);
        for (int i = 0; i < W; i++) begin
            sl = {sl[W-2:0], bits_l};
            sm = {sm[W-2:0], bits_m};
            if (v.poke && i == 2) begin
                start   = 1'b1;
                data_in = ~v.data;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        chk($sformatf("vec%0d_done", idx), {done_l, done_m}, 2'b11);
        chk($sformatf("vec%0d_ones_l", idx), ones_l, v.ones);
        chk($sformatf("vec%0d_ones_m", idx), ones_m, v.ones);
        chk($sformatf("vec%0d_seq_l", idx), sl, v.seq_l);
        chk($sformatf("vec%0d_seq_m", idx), sm, v.seq_m);
        step();
        chk($sformatf("vec%0d_ready", idx), {ready_l, ready_m}, 2'b11);
        $display("vec %0d data=%02h seq_l=%b seq_m=%b ones=%0d/%0d", idx, v.data, sl, sm, ones_l, ones_m);
    endtask

    initial begin
        int starts[$];
        int ends[$];
        int done_ones[$];
        logic prev_valid;
        int done_seen;
        int guard;
        int target;

        vecs[0] = '{8'hB4, 8'b00101101, 8'b10110100, 4, 1'b0};
        vecs[1] = '{8'hFF, 8'b11111111, 8'b11111111, 8, 1'b0};
        vecs[2] = '{8'h00, 8'b00000000, 8'b00000000, 0, 1'b0};
        vecs[3] = '{8'hA5, 8'b10100101, 8'b10100101, 4, 1'b0};
        vecs[4] = '{8'h01, 8'b10000000, 8'b00000001, 1, 1'b0};
        vecs[5] = '{8'hB4, 8'b00101101, 8'b10110100, 4, 1'b1};
        vecs[6] = '{8'h3C, 8'b00111100, 8'b00111100, 4, 1'b0};

        // Reset held with start high: nothing may be accepted.
        reset   = 1'b0;
        start   = 1'b1;
        data_in = 8'hFF;
        step();
        step();
        chk("rst_ready", ready_l, 1'b1);
        chk("rst_valid", valid_l, 1'b0);
        chk("rst_done", done_l, 1'b0);
        chk("rst_ones", ones_l, 0);
        $display("reset: ready=%0b valid=%0b done=%0b ones=%0d", ready_l, valid_l, done_l, ones_l);
        start = 1'b0;
        reset = 1'b1;
        step();

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // start held high: A5 then 3C back to back.
        data_in    = 8'hA5;
        start      = 1'b1;
        prev_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (c == 0) data_in = 8'h3C;
            if (valid_l && !prev_valid) starts.push_back(c);
            if (!valid_l && prev_valid) ends.push_back(c - 1);
            if (done_l) done_ones.push_back(int'(ones_l));
            prev_valid = valid_l;
        end
        start = 1'b0;
        for (int c = 0; c < 12; c++) step();
        chk("b2b_bursts", (starts.size() >= 2 && ends.size() >= 1 && done_ones.size() >= 2), 1);
        if (starts.size() >= 2 && ends.size() >= 1 && done_ones.size() >= 2) begin
            // Last bit, then DONE and IDLE cycles, then next first bit.
            chk("b2b_gap", starts[1] - ends[0], 3);
            chk("b2b_ones0", done_ones[0], 4);
            chk("b2b_ones1", done_ones[1], 4);
            $display("b2b: first_last=%0d second_first=%0d ones=%0d,%0d", ends[0], starts[1], done_ones[0], done_ones[1]);
        end

        // Reset while bit 3 is on the line aborts the word.
        data_in = 8'hB4;
        start   = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("abort_bit3_valid", valid_l, 1'b1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("abort_ready", ready_l, 1'b1);
        chk("abort_valid", valid_l, 1'b0);
        chk("abort_done", done_l, 1'b0);
        chk("abort_ones", ones_l, 0);
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            done_seen += int'(done_l) + int'(valid_l);
        end
        chk("abort_no_done", done_seen, 0);
        $display("abort: ready=%0b valid=%0b done_after=%0d", ready_l, valid_l, done_seen);

        // Random traffic: 100 words with random start patterns.
        target = words_accepted + 100;
        guard  = 0;
        while (words_accepted < target && guard < 3000) begin
            start   = ($urandom_range(0, 3) != 0);
            data_in = W'($urandom);
            step();
            guard++;
        end
        start = 1'b0;
        for (int c = 0; c < 12; c++) step();
        chk("random_budget", (words_accepted >= target), 1);
        $display("random: words=%0d cycles=%0d", words_accepted, guard);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
